// File: rtl/window_gen_3x3.sv
// window_gen_3x3
//   Streaming 3x3 sliding-window generator. Raster-order pixels come in one per
//   handshake. Two line buffers hold the previous two rows and a 3x3 register
//   window shifts left on every accepted pixel. Each fully populated window
//   (stride 1, no padding) is presented as one 9*DATA_W word.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   in_valid    in_pixel valid
//   in_ready    block can accept a pixel this cycle
//   in_pixel    pixel, raster order, frame after frame
//   out_valid   out_window holds a valid window
//   out_ready   downstream accepts the window this cycle
//   out_window  taps; tap k = out_window[k*DATA_W +: DATA_W], tap0 = top-left,
//               tap8 = newest pixel
//   out_last    qualifies the final window of a frame
module window_gen_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [9*DATA_W-1:0]   out_window,
    output logic                  out_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // lb_mid holds row r-1, lb_top holds row r-2, both indexed by column.
    logic [DATA_W-1:0] lb_mid [IMG_W];
    logic [DATA_W-1:0] lb_top [IMG_W];

    // win[i][j]: window row i (0 = oldest), column j (0 = leftmost).
    logic [2:0][2:0][DATA_W-1:0] win;
    logic [2:0][DATA_W-1:0]      new_col;
    logic [9*DATA_W-1:0]         taps;

    logic accept;
    logic col_end;
    logic row_end;
    logic complete;

    // Single output register without skid: take a pixel only when the
    // output slot is free or is being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign col_end  = (col == CW'(IMG_W - 1));
    assign row_end  = (row == RW'(IMG_H - 1));
    // Columns 0/1 still carry the previous row's tail in the shift window,
    // and rows 0/1 have stale line-buffer data; both are gated off here.
    assign complete = (row >= RW'(2)) && (col >= CW'(2));

    assign new_col[0] = lb_top[col];
    assign new_col[1] = lb_mid[col];
    assign new_col[2] = in_pixel;

    // Taps for the pixel being accepted: the two right columns of the
    // current window plus the incoming column.
    for (genvar i = 0; i < 3; i++) begin : g_row
        for (genvar j = 0; j < 3; j++) begin : g_col
            if (j == 2) begin : g_new
                assign taps[(3*i+j)*DATA_W +: DATA_W] = new_col[i];
            end else begin : g_old
                assign taps[(3*i+j)*DATA_W +: DATA_W] = win[i][j+1];
            end
        end
    end

    // Line buffers carry no reset; rows 0/1 of each frame refill them before
    // any window depending on them can be emitted.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[col] <= lb_mid[col];
            lb_mid[col] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col        <= '0;
            row        <= '0;
            win        <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_window <= '0;
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
                win[i][2] <= new_col[i];
            end
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
            if (complete) begin
                out_valid  <= 1'b1;
                out_window <= taps;
                out_last   <= row_end && col_end;
            end else begin
                // in_ready guaranteed any previous window was consumed.
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
module tb_window_gen_3x3;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_pixel;
    logic           out_valid;
    logic           out_ready;
    logic [9*DW-1:0] out_window;
    logic           out_last;

    window_gen_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_window(out_window), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] w;
        logic        l;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model for random traffic: a full frame image plus raster position.
    bit         model_on = 1'b0;
    bit         rand_rdy = 1'b0;
    int         mr = 0;
    int         mc = 0;
    logic [7:0] img [H][W];

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    function automatic logic [71:0] pk(input int b, input int t[9]);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(b + t[k]);
        return r;
    endfunction

    task automatic push_exp(input logic [71:0] w, input logic l);
        exp_t e;
        e.w = w;
        e.l = l;
        q.push_back(e);
    endtask

    // Hand-computed windows of a 4x4 frame holding base+raster index.
    task automatic push_frame(input int b);
        push_exp(pk(b, '{0, 1, 2, 4, 5, 6, 8, 9, 10}), 1'b0);
        push_exp(pk(b, '{1, 2, 3, 5, 6, 7, 9, 10, 11}), 1'b0);
        push_exp(pk(b, '{4, 5, 6, 8, 9, 10, 12, 13, 14}), 1'b0);
        push_exp(pk(b, '{5, 6, 7, 9, 10, 11, 13, 14, 15}), 1'b1);
    endtask

    task automatic model_accept(input logic [7:0] v);
        logic [71:0] w;
        img[mr][mc] = v;
        if (mr >= 2 && mc >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w[(3*i+j)*8 +: 8] = img[mr-2+i][mc-2+j];
            push_exp(w, (mr == H-1) && (mc == W-1));
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] v);
        int  n;
        bit  acc;
        in_valid = 1'b1;
        in_pixel = v;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stuck 0 for pixel %0d", v);
        end else if (model_on) begin
            model_accept(v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic stream(input int b);
        for (int k = 0; k < 16; k++) send(8'(b + k));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        mr = 0;
        mc = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every output handshake; also checks hold stability.
    bit          hold = 1'b0;
    logic [71:0] hold_win;
    logic        hold_last;

    always @(negedge clk) begin
        exp_t e;
        if (hold) begin
            chk("hold_valid", 72'(out_valid), 72'(1));
            chk("hold_window", out_window, hold_win);
            chk("hold_last", 72'(out_last), 72'(hold_last));
        end
        hold      = reset && out_valid && !out_ready;
        hold_win  = out_window;
        hold_last = out_last;
        if (reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_window: got %h expected none", out_window);
            end else begin
                e = q.pop_front();
                chk("window", out_window, e.w);
                chk("last", 72'(out_last), 72'(e.l));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int n;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b1;
        idle(2);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_valid", 72'(out_valid), 72'(0));
        chk("rst_last", 72'(out_last), 72'(0));
        chk("rst_window", out_window, 72'(0));
        chk("rst_in_ready", 72'(in_ready), 72'(1));
        idle(1);

        // 1: single frame, free-flowing output
        push_frame(0);
        stream(0);
        idle(3);

        // 2: backpressure after the first window
        push_frame(0);
        out_ready = 1'b0;
        for (int k = 0; k <= 10; k++) send(8'(k));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 72'(out_valid), 72'(1));
            chk("bp_in_ready", 72'(in_ready), 72'(0));
            chk("bp_window", out_window, pk(0, '{0, 1, 2, 4, 5, 6, 8, 9, 10}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 11; k < 16; k++) send(8'(k));
        idle(3);

        // 3: two frames back to back
        push_frame(0);
        push_frame(100);
        stream(0);
        stream(100);
        idle(3);

        // 4: reset in mid-frame, then a clean frame
        for (int k = 0; k <= 9; k++) send(8'(k));
        do_reset();
        push_frame(0);
        stream(0);
        idle(3);

        // 6: reset while a window is pending
        out_ready = 1'b0;
        for (int k = 0; k <= 10; k++) send(8'(k));
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst6_valid", 72'(out_valid), 72'(0));
        chk("rst6_last", 72'(out_last), 72'(0));
        chk("rst6_window", out_window, 72'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        mr = 0;
        mc = 0;

        // 5: random valid/ready over three frames against the model
        model_on = 1'b1;
        rand_rdy = 1'b1;
        for (int k = 0; k < 3 * W * H; k++) begin
            if ($urandom_range(0, 1) == 1) idle(1);
            send(8'($urandom_range(0, 255)));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        model_on  = 1'b0;

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        idle(2);
        chk("queue_empty", 72'(q.size()), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
